// File: rtl/sd_tx_pkg.sv
// rtl/sd_tx_pkg.sv - shared types and defaults for the SD transmit scheduler
package sd_tx_pkg;

    localparam int BLKCNT_W_DEF = 16;
    localparam int WLEN_W_DEF   = 10;
    localparam int GAP_W_DEF    = 8;

    localparam logic [1:0] WIDTH_1B = 2'b00;
    localparam logic [1:0] WIDTH_4B = 2'b01;
    localparam logic [1:0] WIDTH_8B = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } sd_tx_state_e;

endpackage

// File: rtl/sd_tx_word_reg.sv
// rtl/sd_tx_word_reg.sv - single-entry valid/ready holding register for engine words
module sd_tx_word_reg (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_last  <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load && !flush) begin
                out_data <= load_data;
                out_last <= load_last;
            end
        end
    end

endmodule

// File: rtl/sd_tx_sched.sv
// rtl/sd_tx_sched.sv - block/gap scheduler feeding source words to the SD transmit engine
module sd_tx_sched
    import sd_tx_pkg::*;
#(
    parameter int BLKCNT_W = BLKCNT_W_DEF,
    parameter int WLEN_W   = WLEN_W_DEF,
    parameter int GAP_W    = GAP_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          cfg_width,
    input  logic                cfg_ddr,
    input  logic [WLEN_W-1:0]   cfg_blk_words,
    input  logic [BLKCNT_W-1:0] cfg_blk_cnt,
    input  logic [GAP_W-1:0]    cfg_gap,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [BLKCNT_W-1:0] blk_done_cnt,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [31:0]         src_data,
    output logic                tx_en,
    output logic [1:0]          tx_width,
    output logic                tx_ddr,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [31:0]         tx_data,
    output logic                tx_last,
    input  logic                tx_active
);

    sd_tx_state_e state, state_nxt;

    logic [WLEN_W-1:0]   lat_words;
    logic [BLKCNT_W-1:0] lat_cnt;
    logic [GAP_W-1:0]    lat_gap;
    logic [GAP_W-1:0]    gap_cnt;
    logic [WLEN_W-1:0]   fetched;
    logic                seen_active;

    logic                start_ok;
    logic                kill;
    logic                src_xfer;
    logic                load_last;
    logic                last_acc;
    logic                drain_exit;
    logic                gap_exit;
    logic [BLKCNT_W-1:0] blk_next;

    assign start_ok   = start && (cfg_blk_words != '0) && (cfg_blk_cnt != '0);
    assign kill       = abort && (state != ST_IDLE);
    assign last_acc   = tx_valid && tx_ready && tx_last;
    assign gap_exit   = (gap_cnt == '0) && !tx_active;
    assign drain_exit = (state == ST_DRAIN) && !tx_active && seen_active;
    assign blk_next   = blk_done_cnt + BLKCNT_W'(1);
    assign load_last  = (fetched == lat_words - WLEN_W'(1));

    // Abort suppresses fetching so nothing new lands in the word register as it is flushed
    assign src_ready = (state == ST_STREAM) && !abort && (fetched < lat_words)
                       && (!tx_valid || tx_ready);
    assign src_xfer  = src_valid && src_ready;

    assign busy  = (state != ST_IDLE);
    assign tx_en = busy;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_ok) state_nxt = ST_GAP;
            ST_GAP:    if (gap_exit) state_nxt = ST_STREAM;
            ST_STREAM: if (last_acc) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (drain_exit) state_nxt = (blk_next == lat_cnt) ? ST_DONE : ST_GAP;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (kill) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_width     <= WIDTH_1B;
            tx_ddr       <= 1'b0;
            lat_words    <= '0;
            lat_cnt      <= '0;
            lat_gap      <= '0;
            gap_cnt      <= '0;
            fetched      <= '0;
            seen_active  <= 1'b0;
            blk_done_cnt <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= (state == ST_DONE) && !abort;
            err  <= ((state == ST_IDLE) && start && !start_ok) || kill;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        tx_width     <= cfg_width;
                        tx_ddr       <= cfg_ddr;
                        lat_words    <= cfg_blk_words;
                        lat_cnt      <= cfg_blk_cnt;
                        lat_gap      <= cfg_gap;
                        gap_cnt      <= cfg_gap;
                        blk_done_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_exit) begin
                        fetched <= '0;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (src_xfer) fetched <= fetched + WLEN_W'(1);
                    if (last_acc) seen_active <= 1'b0;
                end
                ST_DRAIN: begin
                    if (tx_active) seen_active <= 1'b1;
                    if (drain_exit && !abort) begin
                        blk_done_cnt <= blk_next;
                        gap_cnt      <= lat_gap;
                    end
                end
                default: ;
            endcase
        end
    end

    sd_tx_word_reg u_word_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (kill),
        .load      (src_xfer),
        .load_data (src_data),
        .load_last (load_last),
        .out_ready (tx_ready),
        .out_valid (tx_valid),
        .out_data  (tx_data),
        .out_last  (tx_last)
    );

endmodule

// File: tb/tb_sd_tx_sched.sv
// tb/tb_sd_tx_sched.sv - scoreboard bench for the SD transmit scheduler
module tb_sd_tx_sched;
    import sd_tx_pkg::*;

    localparam int BW = 16;
    localparam int WW = 10;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    cfg_width = 2'b11;
    logic          cfg_ddr = 1'b1;
    logic [WW-1:0] cfg_blk_words = '0;
    logic [BW-1:0] cfg_blk_cnt = '0;
    logic [GW-1:0] cfg_gap = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, err;
    logic [BW-1:0] blk_done_cnt;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [31:0]   src_data = 32'd0;
    logic          tx_en;
    logic [1:0]    tx_width;
    logic          tx_ddr;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [31:0]   tx_data;
    logic          tx_last;
    logic          tx_active = 1'b0;

    sd_tx_sched #(.BLKCNT_W(BW), .WLEN_W(WW), .GAP_W(GW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_width     (cfg_width),
        .cfg_ddr       (cfg_ddr),
        .cfg_blk_words (cfg_blk_words),
        .cfg_blk_cnt   (cfg_blk_cnt),
        .cfg_gap       (cfg_gap),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .blk_done_cnt  (blk_done_cnt),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_data      (src_data),
        .tx_en         (tx_en),
        .tx_width      (tx_width),
        .tx_ddr        (tx_ddr),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .tx_active     (tx_active)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [32:0] exp_q[$];
    int          blk_words_m = 1;
    int          widx = 0;
    logic [31:0] next_data = 32'd0;
    bit          src_rand = 1'b0;
    bit          rdy_third = 1'b0;
    int          active_len = 3;
    int          active_cnt = 0;
    int          cyc = 0;
    int          rx_cnt = 0;
    int          last_hs = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    // Source, engine model and scoreboard: drive on the falling edge, observe 1 ns later
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            tx_active = (active_cnt > 0);
            if (active_cnt > 0) active_cnt--;
            src_valid = src_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_ready  = rdy_third ? (cyc % 3 == 0) : 1'b1;
            src_data  = next_data;
            #1;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (prev_stall) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, prev_data);
                check("hold_last", tx_last, prev_last);
            end
            prev_stall = tx_valid && !tx_ready && !abort && reset_n;
            prev_data  = tx_data;
            prev_last  = tx_last;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e[31:0]);
                    check("tx_last", tx_last, e[32]);
                end
                rx_cnt++;
                if (tx_last) begin
                    last_hs++;
                    active_cnt = active_len;
                end
            end
            if (src_valid && src_ready) begin
                exp_q.push_back({(widx == blk_words_m - 1), next_data});
                next_data++;
                widx = (widx == blk_words_m - 1) ? 0 : widx + 1;
            end
        end
    end

    task automatic start_xfer(input logic [1:0] w, input logic d, input int words,
                              input int cnt, input int gap);
        @(negedge clk);
        cfg_width     = w;
        cfg_ddr       = d;
        cfg_blk_words = WW'(words);
        cfg_blk_cnt   = BW'(cnt);
        cfg_gap       = GW'(gap);
        blk_words_m   = (words == 0) ? 1 : words;
        widx          = 0;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (!busy) break;
        end
        if (i == budget) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_rx(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (rx_cnt >= target) break;
        end
        if (i == budget) check("rx_timeout", 0, 1);
    endtask

    task automatic wait_last(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (last_hs >= target) break;
        end
        if (i == budget) check("last_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, r0, l0;

        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_tx_en", tx_en, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_tx_ddr", tx_ddr, 0);
        check("rst_tx_width", tx_width, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_blk_done", blk_done_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // First-word latency with zero gap
        d0 = done_cnt;
        next_data = 32'hA000_0000;
        start_xfer(WIDTH_1B, 1'b0, 2, 1, 0);
        #2;
        check("lat_t1_busy", busy, 1);
        check("lat_t1_src_ready", src_ready, 0);
        check("lat_t1_tx_valid", tx_valid, 0);
        @(negedge clk); #2;
        check("lat_t2_src_ready", src_ready, 1);
        check("lat_t2_tx_valid", tx_valid, 0);
        @(negedge clk); #2;
        check("lat_t3_tx_valid", tx_valid, 1);
        check("lat_t3_tx_data", tx_data, 32'hA000_0000);
        wait_idle(300);
        check("lat_done", done_cnt - d0, 1);
        check("lat_blk_done", blk_done_cnt, 1);

        // 1b SDR, 4 words x 2 blocks, gap 3
        d0 = done_cnt; r0 = rx_cnt; l0 = last_hs;
        next_data = 32'h1000_0000;
        start_xfer(WIDTH_1B, 1'b0, 4, 2, 3);
        wait_idle(500);
        check("basic_words", rx_cnt - r0, 8);
        check("basic_lasts", last_hs - l0, 2);
        check("basic_done", done_cnt - d0, 1);
        check("basic_blk_done", blk_done_cnt, 2);
        check("basic_q_empty", exp_q.size(), 0);

        // Throttled engine and bursty source
        d0 = done_cnt; r0 = rx_cnt;
        src_rand = 1'b1; rdy_third = 1'b1;
        next_data = 32'h2000_0000;
        start_xfer(WIDTH_8B, 1'b0, 5, 3, 2);
        #2;
        check("thr_tx_width", tx_width, WIDTH_8B);
        wait_idle(3000);
        check("thr_words", rx_cnt - r0, 15);
        check("thr_blk_done", blk_done_cnt, 3);
        check("thr_done", done_cnt - d0, 1);
        check("thr_q_empty", exp_q.size(), 0);
        src_rand = 1'b0; rdy_third = 1'b0;

        // Abort after the second accepted word, 4b DDR
        d0 = done_cnt; e0 = err_cnt; r0 = rx_cnt;
        next_data = 32'h3000_0000;
        start_xfer(WIDTH_4B, 1'b1, 8, 2, 1);
        #2;
        check("abt_tx_width", tx_width, WIDTH_4B);
        check("abt_tx_ddr", tx_ddr, 1);
        wait_rx(r0 + 2, 200);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        check("abt_busy", busy, 0);
        check("abt_tx_valid", tx_valid, 0);
        check("abt_src_ready", src_ready, 0);
        check("abt_err", err, 1);
        check("abt_blk_done", blk_done_cnt, 0);
        exp_q.delete();
        widx = 0;
        repeat (20) @(negedge clk);
        #2;
        check("abt_err_pulses", err_cnt - e0, 1);
        check("abt_no_done", done_cnt - d0, 0);

        // Illegal configurations
        e0 = err_cnt;
        start_xfer(WIDTH_1B, 1'b0, 0, 2, 0);
        #2;
        check("ill_w0_err", err, 1);
        check("ill_w0_busy", busy, 0);
        start_xfer(WIDTH_1B, 1'b0, 4, 0, 0);
        #2;
        check("ill_c0_err", err, 1);
        check("ill_c0_busy", busy, 0);
        @(negedge clk); #2;
        check("ill_err_pulses", err_cnt - e0, 2);
        check("ill_busy_after", busy, 0);

        // Engine stays active 10 cycles after each block
        d0 = done_cnt; l0 = last_hs;
        active_len = 10;
        next_data = 32'h4000_0000;
        start_xfer(WIDTH_1B, 1'b0, 2, 2, 0);
        wait_last(l0 + 1, 200);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); #2;
            check("drn_blk_hold", blk_done_cnt, 0);
            check("drn_no_fetch", src_ready, 0);
        end
        @(negedge clk); #2;
        check("drn_blk_inc", blk_done_cnt, 1);
        check("drn_busy", busy, 1);
        wait_idle(300);
        check("drn_blk_final", blk_done_cnt, 2);
        check("drn_done", done_cnt - d0, 1);
        active_len = 3;

        // Abort coincident with start in idle: start wins
        e0 = err_cnt;
        abort = 1'b1;
        next_data = 32'h5000_0000;
        start_xfer(WIDTH_1B, 1'b0, 4, 1, 5);
        abort = 1'b0;
        #2;
        check("sa_busy", busy, 1);
        check("sa_blk_clr", blk_done_cnt, 0);
        check("sa_no_err", err_cnt - e0, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        check("sa_abort_idle", busy, 0);
        check("sa_abort_err", err_cnt - e0, 1);
        exp_q.delete();
        widx = 0;

        // Reset mid-transfer discards the held word silently
        d0 = done_cnt; e0 = err_cnt; r0 = rx_cnt;
        active_len = 3;
        next_data = 32'h6000_0000;
        rdy_third = 1'b1;
        start_xfer(WIDTH_8B, 1'b1, 8, 1, 0);
        wait_rx(r0 + 1, 200);
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        check("mrst_tx_valid", tx_valid, 0);
        check("mrst_tx_data", tx_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_tx_ddr", tx_ddr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        rdy_third = 1'b0;
        exp_q.delete();
        widx = 0;
        repeat (5) @(negedge clk);
        #2;
        check("mrst_no_done", done_cnt - d0, 0);
        check("mrst_no_err", err_cnt - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
